// File: rtl/fetch_sequencer.sv
// Program-memory fetch sequencer with a byte-granular circular prefetch buffer feeding decode.
// Optional FETCH_PERF_EN macro adds a saturating stall_cycles counter output.
// state         | meaning
// FETCH_IDLE    | no read outstanding; waits for >=4 free bytes
// FETCH_WAIT    | read outstanding; its data is appended on ack
// FETCH_DISCARD | read outstanding but stale after a redirect; data dropped on ack
module fetch_sequencer #(
  parameter int WORD_WIDTH         = 32,
  parameter int PROGRAM_ADDR_WIDTH = 16,
  parameter int BUF_BYTES          = 16,
  parameter int RESET_PC           = 0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  output logic                                pmem_req,
  output logic [PROGRAM_ADDR_WIDTH-1:0]       pmem_addr,
  input  logic                                pmem_ack,
  input  logic [31:0]                         pmem_data,
  input  logic                                redirect,
  input  logic [PROGRAM_ADDR_WIDTH-1:0]       redirect_pc,
  input  logic                                consume,
  input  logic [3:0]                          consume_len,
  output logic [PROGRAM_ADDR_WIDTH-1:0]       pc,
  output logic [8*(1+WORD_WIDTH/8)-1:0]       window,
  output logic [3:0]                          window_count
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]                         stall_cycles
`endif
);

  localparam int AW  = PROGRAM_ADDR_WIDTH;
  localparam int WIN = 1 + WORD_WIDTH / 8;
  localparam int PW  = $clog2(BUF_BYTES);
  localparam int OW  = $clog2(BUF_BYTES + 1);
  localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DISCARD
  } state_t;

  state_t          state_q;
  logic            req_q;
  logic [AW-1:0]   req_addr_q;
  logic [AW-1:0]   fetch_addr_q;
  logic [1:0]      drop_q;
  logic [AW-1:0]   pc_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [OW-1:0]   occ_q;
  logic [7:0]      buf_q [BUF_BYTES];

  logic            pop_ok;
  logic            illegal_consume;
  logic [OW-1:0]   pop_len;
  logic [OW-1:0]   push_len;
  logic [OW-1:0]   occ_d;
  logic            space_ok;
  logic [AW-1:0]   redirect_word;

  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [OW-1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= BUF_BYTES) s = s - BUF_BYTES;
    return PW'(s);
  endfunction

  assign pmem_req      = req_q;
  assign pmem_addr     = req_addr_q;
  assign pc            = pc_q;
  assign window_count  = (occ_q >= OW'(WIN)) ? 4'(WIN) : 4'(occ_q);
  assign redirect_word = {redirect_pc[AW-1:2], 2'b00};

  assign pop_ok          = consume && !redirect && (consume_len != 4'd0) && (consume_len <= window_count);
  assign illegal_consume = consume && !redirect && !pop_ok;
  assign pop_len         = pop_ok ? OW'(consume_len) : '0;
  assign push_len        = (state_q == FETCH_WAIT && pmem_ack && !redirect)
                           ? OW'(3'd4 - {1'b0, drop_q}) : '0;
  // Space check sees this cycle's pop and append so back-to-back requests never overfill.
  assign occ_d           = occ_q - pop_len + push_len;
  assign space_ok        = (occ_d <= OW'(BUF_BYTES - 4));

  always_comb begin
    window = '0;
    for (int i = 0; i < WIN; i++) begin
      window[8*i +: 8] = buf_q[ptr_add(rd_ptr_q, OW'(i))];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH_IDLE;
      req_q        <= 1'b0;
      req_addr_q   <= {RST_PC[AW-1:2], 2'b00};
      fetch_addr_q <= {RST_PC[AW-1:2], 2'b00};
      drop_q       <= RST_PC[1:0];
      pc_q         <= RST_PC;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      for (int i = 0; i < BUF_BYTES; i++) buf_q[i] <= 8'h00;
    end else if (redirect) begin
      pc_q         <= redirect_pc;
      fetch_addr_q <= redirect_word;
      drop_q       <= redirect_pc[1:0];
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      occ_q        <= '0;
      case (state_q)
        FETCH_IDLE: begin
          state_q <= FETCH_IDLE;
          req_q   <= 1'b0;
        end
        default: begin
          // An open handshake is never retracted; only an acked one may restart at the new target.
          if (pmem_ack) begin
            state_q    <= FETCH_WAIT;
            req_q      <= 1'b1;
            req_addr_q <= redirect_word;
          end else begin
            state_q <= FETCH_DISCARD;
            req_q   <= 1'b1;
          end
        end
      endcase
    end else begin
      if (pop_ok) pc_q <= pc_q + AW'(consume_len);
      rd_ptr_q <= ptr_add(rd_ptr_q, pop_len);
      wr_ptr_q <= ptr_add(wr_ptr_q, push_len);
      occ_q    <= occ_d;
      if (push_len != '0) begin
        for (int k = 0; k < 4; k++) begin
          if (k >= int'(drop_q))
            buf_q[ptr_add(wr_ptr_q, OW'(k - int'(drop_q)))] <= pmem_data[8*k +: 8];
        end
      end
      case (state_q)
        FETCH_IDLE: begin
          if (space_ok) begin
            state_q    <= FETCH_WAIT;
            req_q      <= 1'b1;
            req_addr_q <= fetch_addr_q;
          end
        end
        FETCH_WAIT: begin
          if (pmem_ack) begin
            drop_q       <= 2'd0;
            fetch_addr_q <= fetch_addr_q + AW'(4);
            if (space_ok) begin
              state_q    <= FETCH_WAIT;
              req_q      <= 1'b1;
              req_addr_q <= fetch_addr_q + AW'(4);
            end else begin
              state_q <= FETCH_IDLE;
              req_q   <= 1'b0;
            end
          end
        end
        FETCH_DISCARD: begin
          if (pmem_ack) begin
            state_q    <= FETCH_WAIT;
            req_q      <= 1'b1;
            req_addr_q <= fetch_addr_q;
          end
        end
        default: begin
          state_q <= FETCH_IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_q;
  assign stall_cycles = stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (redirect) begin
      stall_q <= '0;
    end else if (window_count < 4'(WIN) && stall_q != '1) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`endif

  a_legal_consume: assert property (@(posedge clk) disable iff (!reset_n) !illegal_consume)
    else $warning("fetch_sequencer: consume_len beyond window_count ignored");

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: fill, mixed consume, redirects, reset and illegal consume.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        pmem_req;
  logic [15:0] pmem_addr;
  logic        pmem_ack;
  logic [31:0] pmem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        consume;
  logic [3:0]  consume_len;
  logic [15:0] pc;
  logic [39:0] window;
  logic [3:0]  window_count;

  int n_cmp = 0;
  int n_err = 0;
  int lat = 0;
  int acks = 0;

  fetch_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pmem_req     (pmem_req),
    .pmem_addr    (pmem_addr),
    .pmem_ack     (pmem_ack),
    .pmem_data    (pmem_data),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .consume      (consume),
    .consume_len  (consume_len),
    .pc           (pc),
    .window       (window),
    .window_count (window_count)
  );

  always #5 clk = ~clk;

  // Bytes 0..7 are 11 22 .. 88; elsewhere an address hash.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a < 16'd8) return 8'((a + 16'd1) * 16'd17);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {mem_byte(a + 16'd3), mem_byte(a + 16'd2), mem_byte(a + 16'd1), mem_byte(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory responder: acks after `lat` waiting cycles.
  initial begin
    int cnt;
    cnt = 0;
    pmem_ack = 1'b0;
    pmem_data = 32'h0;
    forever begin
      @(negedge clk);
      if (reset_n && pmem_req) begin
        if (cnt >= lat) begin
          pmem_ack  = 1'b1;
          pmem_data = mem_word(pmem_addr);
          cnt = 0;
        end else begin
          pmem_ack = 1'b0;
          cnt++;
        end
      end else begin
        pmem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (reset_n && pmem_req && pmem_ack) acks++;
  end

  initial begin
    logic [3:0]  lens [4];
    logic [15:0] pcs [4];
    int a0;
    lens = '{4'd1, 4'd2, 4'd3, 4'd5};
    pcs  = '{16'd1, 16'd3, 16'd6, 16'd11};
    redirect = 1'b0;
    redirect_pc = '0;
    consume = 1'b0;
    consume_len = '0;

    repeat (2) @(negedge clk);
    chk("rst_req", pmem_req, 0);
    chk("rst_addr", pmem_addr, 0);
    chk("rst_pc", pc, 0);
    chk("rst_wcount", window_count, 0);
    chk("rst_window", window, 0);
    reset_n = 1'b1;

    // Reset fetch with zero-wait memory
    for (int n = 0; n < 20 && !pmem_req; n++) @(negedge clk);
    chk("first_req", pmem_req, 1);
    chk("first_addr", pmem_addr, 16'h0000);
    @(negedge clk);
    chk("second_addr", pmem_addr, 16'h0004);
    for (int n = 0; n < 20 && window_count != 4'd5; n++) @(negedge clk);
    chk("fill_wcount", window_count, 5);
    chk("fill_byte0", window[7:0], 8'h11);
    chk("fill_window", window, 40'h5544332211);

    // Full buffer without consume
    repeat (10) @(negedge clk);
    chk("full_req", pmem_req, 0);
    chk("full_acks", acks, 4);
    chk("full_occ", dut.occ_q, 16);

    // Mixed-length consume back to back
    for (int i = 0; i < 4; i++) begin
      consume = 1'b1;
      consume_len = lens[i];
      @(negedge clk);
      chk("mix_pc", pc, pcs[i]);
      chk("mix_byte0", window[7:0], mem_byte(pcs[i]));
    end
    consume = 1'b0;

    // Unaligned redirect
    redirect = 1'b1;
    redirect_pc = 16'h0102;
    @(negedge clk);
    redirect = 1'b0;
    chk("redir_pc", pc, 16'h0102);
    chk("redir_flush", window_count, 0);
    for (int n = 0; n < 20 && !pmem_req; n++) @(negedge clk);
    chk("redir_addr", pmem_addr, 16'h0100);
    for (int n = 0; n < 20 && window_count == 4'd0; n++) @(negedge clk);
    chk("redir_wcount", window_count, 2);
    chk("redir_byte0", window[7:0], mem_byte(16'h0102));
    chk("redir_byte1", window[15:8], mem_byte(16'h0103));

    // Redirect while a slow request is outstanding
    lat = 4;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 20 && !pmem_req; n++) @(negedge clk);
    chk("slow_req", pmem_req, 1);
    @(negedge clk);
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    a0 = acks;
    @(negedge clk);
    redirect = 1'b0;
    chk("disc_req_held", pmem_req, 1);
    chk("disc_addr_held", pmem_addr, 16'h0000);
    chk("disc_pc", pc, 16'h0040);
    for (int n = 0; n < 20 && acks == a0; n++) @(negedge clk);
    chk("disc_ack", acks, a0 + 1);
    chk("disc_next_req", pmem_req, 1);
    chk("disc_next_addr", pmem_addr, 16'h0040);
    chk("disc_dropped", window_count, 0);
    for (int n = 0; n < 60 && window_count != 4'd5; n++) @(negedge clk);
    chk("disc_byte0", window[7:0], mem_byte(16'h0040));

    // Reset during an outstanding request
    for (int n = 0; n < 20 && !pmem_req; n++) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_req", pmem_req, 0);
    chk("mid_rst_pc", pc, 0);
    chk("mid_rst_wcount", window_count, 0);

    // Illegal consume at window_count 3, then exact-fit consume
    @(negedge clk);
    reset_n = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0101;
    @(negedge clk);
    redirect = 1'b0;
    for (int n = 0; n < 30 && window_count == 4'd0; n++) @(negedge clk);
    chk("ill_wcount", window_count, 3);
    chk("ill_byte0", window[7:0], mem_byte(16'h0101));
    consume = 1'b1;
    consume_len = 4'd5;
    #1;
    chk("ill_flag", dut.illegal_consume, 1);
    @(negedge clk);
    chk("ill_pc", pc, 16'h0101);
    chk("ill_wcount_kept", window_count, 3);
    consume_len = 4'd3;
    @(negedge clk);
    consume = 1'b0;
    chk("exact_pc", pc, 16'h0104);
    chk("exact_wcount", window_count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
